// File: rtl/icache_pkg.sv
// Shared widths, FSM encoding and tag-width helper
// for the direct-mapped instruction cache.
package icache_pkg;

  localparam int ICACHE_ADDR_W  = 32;
  localparam int ICACHE_INSTR_W = 32;
  localparam int ICACHE_INDEX_W = 7;

  typedef enum logic {
    ICACHE_IDLE      = 1'b0,
    ICACHE_MISS_WAIT = 1'b1
  } icache_state_e;

  function automatic int icache_tag_w(
    input int addr_w,
    input int index_w
  );
    return addr_w - index_w - 2;
  endfunction

endpackage

// File: rtl/icache_perf_cnt.sv
// Saturating event counter with enable;
// holds at all-ones instead of wrapping.
module icache_perf_cnt #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  output logic [W-1:0] cnt
);

  logic [W-1:0] cnt_d;
  logic [W-1:0] cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    if (en && (cnt_q != '1)) begin
      cnt_d = cnt_q + W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/icache.sv
// Direct-mapped one-word-per-line instruction cache
// with MCU refill, fence.i flush and perf counters.
module icache
  import icache_pkg::*;
#(
  parameter int ADDR_W  = ICACHE_ADDR_W,
  parameter int INDEX_W = ICACHE_INDEX_W,
  parameter int CNT_W   = 32
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      rdy,
  input  logic [ADDR_W-1:0]         pc_i,
  input  logic                      pc_valid,
  input  logic                      flush,
  input  logic                      fill_we,
  input  logic [ICACHE_INSTR_W-1:0] fill_instr,
  output logic                      missed,
  output logic [ICACHE_INSTR_W-1:0] instr_o,
  output logic                      busy,
  output logic [CNT_W-1:0]          hit_cnt,
  output logic [CNT_W-1:0]          miss_cnt
);

  localparam int LINES  = 2 ** INDEX_W;
  localparam int TAG_W  = icache_tag_w(ADDR_W, INDEX_W);
  localparam int LINE_W = ADDR_W - 2;

  logic [ICACHE_INSTR_W-1:0] data_q [LINES];
  logic [TAG_W-1:0]          tag_q  [LINES];
  logic [LINES-1:0]          valid_d;
  logic [LINES-1:0]          valid_q;

  icache_state_e state_d;
  icache_state_e state_q;
  logic [LINE_W-1:0] miss_line_d;
  logic [LINE_W-1:0] miss_line_q;

  logic [INDEX_W-1:0] idx;
  logic [TAG_W-1:0]   tag;
  logic               hit;
  logic [INDEX_W-1:0] fill_idx;
  logic [TAG_W-1:0]   fill_tag;
  logic               fill_wr;
  logic               hit_inc;
  logic               miss_inc;
  logic               unused_pc;

  assign idx = pc_i[INDEX_W+1:2];
  assign tag = pc_i[ADDR_W-1:INDEX_W+2];
  assign unused_pc = ^pc_i[1:0];

  assign hit = pc_valid & valid_q[idx]
             & (tag_q[idx] == tag);
  assign missed  = pc_valid & ~hit;
  assign instr_o = hit ? data_q[idx] : '0;
  assign busy = (state_q == ICACHE_MISS_WAIT);

  assign fill_idx = miss_line_q[INDEX_W-1:0];
  assign fill_tag = miss_line_q[LINE_W-1:INDEX_W];

  always_comb begin
    state_d     = state_q;
    miss_line_d = miss_line_q;
    valid_d     = valid_q;
    fill_wr     = 1'b0;
    hit_inc     = 1'b0;
    miss_inc    = 1'b0;
    if (rdy) begin
      if (flush) begin
        // flush beats any fill or new miss this cycle
        valid_d = '0;
        state_d = ICACHE_IDLE;
      end else begin
        unique case (state_q)
          ICACHE_IDLE: begin
            if (missed) begin
              miss_line_d = pc_i[ADDR_W-1:2];
              miss_inc    = 1'b1;
              state_d     = ICACHE_MISS_WAIT;
            end else if (hit) begin
              hit_inc = 1'b1;
            end
          end
          ICACHE_MISS_WAIT: begin
            if (fill_we) begin
              fill_wr           = 1'b1;
              valid_d[fill_idx] = 1'b1;
              state_d           = ICACHE_IDLE;
            end
          end
          default: state_d = ICACHE_IDLE;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ICACHE_IDLE;
      miss_line_q <= '0;
      valid_q     <= '0;
    end else begin
      state_q     <= state_d;
      miss_line_q <= miss_line_d;
      valid_q     <= valid_d;
    end
  end

  // data and tags are qualified by valid, so no reset
  always_ff @(posedge clk) begin
    if (fill_wr) begin
      data_q[fill_idx] <= fill_instr;
      tag_q[fill_idx]  <= fill_tag;
    end
  end

  icache_perf_cnt #(.W(CNT_W)) u_hit_cnt (
    .clk   (clk),
    .rst_n (rst),
    .en    (hit_inc),
    .cnt   (hit_cnt)
  );

  icache_perf_cnt #(.W(CNT_W)) u_miss_cnt (
    .clk   (clk),
    .rst_n (rst),
    .en    (miss_inc),
    .cnt   (miss_cnt)
  );

endmodule

// File: tb/tb_icache.sv
// Scoreboard bench for icache; small counters
// so saturation is reachable.
module tb_icache;

  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          rdy;
  logic [31:0]   pc_i;
  logic          pc_valid;
  logic          flush;
  logic          fill_we;
  logic [31:0]   fill_instr;
  logic          missed;
  logic [31:0]   instr_o;
  logic          busy;
  logic [CW-1:0] hit_cnt;
  logic [CW-1:0] miss_cnt;

  icache #(.CNT_W(CW)) dut (
    .clk        (clk),
    .rst        (rst_n),
    .rdy        (rdy),
    .pc_i       (pc_i),
    .pc_valid   (pc_valid),
    .flush      (flush),
    .fill_we    (fill_we),
    .fill_instr (fill_instr),
    .missed     (missed),
    .instr_o    (instr_o),
    .busy       (busy),
    .hit_cnt    (hit_cnt),
    .miss_cnt   (miss_cnt)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic          missed;
    logic [31:0]   instr;
    logic          busy;
    logic [CW-1:0] hit;
    logic [CW-1:0] miss;
  } exp_t;

  exp_t sb[$];
  int   n_chk = 0;
  int   n_err = 0;

  bit          mv [128];
  logic [22:0] mt [128];
  logic [31:0] md [128];
  bit          mb;
  logic [29:0] ml;
  int          mh;
  int          mm;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic model_rst();
    foreach (mv[i]) mv[i] = 1'b0;
    mb = 1'b0;
    ml = '0;
    mh = 0;
    mm = 0;
  endtask

  task automatic step(input logic [31:0] pc,
                      input bit v,
                      input bit fl = 1'b0,
                      input bit fw = 1'b0,
                      input logic [31:0] fi = '0,
                      input bit r = 1'b1);
    exp_t e;
    exp_t g;
    int   ix;
    bit   h;
    pc_i = pc;
    pc_valid = v;
    flush = fl;
    fill_we = fw;
    fill_instr = fi;
    rdy = r;
    ix = int'(pc[8:2]);
    h = v && mv[ix] && (mt[ix] == pc[31:9]);
    e.missed = v && !h;
    e.instr = h ? md[ix] : 32'h0;
    e.busy = mb;
    e.hit = CW'(mh);
    e.miss = CW'(mm);
    sb.push_back(e);
    #4;
    g = sb.pop_front();
    chk("missed", 32'(missed), 32'(g.missed));
    chk("instr", instr_o, g.instr);
    chk("busy", 32'(busy), 32'(g.busy));
    chk("hit_cnt", 32'(hit_cnt), 32'(g.hit));
    chk("miss_cnt", 32'(miss_cnt), 32'(g.miss));
    if (r) begin
      if (fl) begin
        foreach (mv[i]) mv[i] = 1'b0;
        mb = 1'b0;
      end else if (!mb) begin
        if (e.missed) begin
          ml = pc[31:2];
          mb = 1'b1;
          if (mm < 15) mm++;
        end else if (h) begin
          if (mh < 15) mh++;
        end
      end else if (fw) begin
        mv[ml[6:0]] = 1'b1;
        mt[ml[6:0]] = ml[29:7];
        md[ml[6:0]] = fi;
        mb = 1'b0;
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0;
    rdy = 1'b1;
    pc_i = 32'h1000;
    pc_valid = 1'b1;
    flush = 1'b0;
    fill_we = 1'b0;
    fill_instr = '0;
    model_rst();
    #1;
    chk("rst_missed", 32'(missed), 32'd1);
    chk("rst_instr", instr_o, 32'h0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_hit", 32'(hit_cnt), 32'd0);
    chk("rst_miss", 32'(miss_cnt), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    step(32'h1000, 1);
    chk("t1_busy", 32'(busy), 32'd1);
    chk("t1_mcnt", 32'(miss_cnt), 32'd1);
    step(32'h1000, 1, 0, 1, 32'h0000_0013);
    step(32'h1000, 1);
    step(32'h1000, 1);
    chk("t1_hcnt", 32'(hit_cnt), 32'd2);

    step(32'h1200, 1);
    step(32'h1200, 1, 0, 1, 32'h0010_0093);
    step(32'h1000, 1);
    step(32'h1000, 1, 0, 1, 32'h0000_0013);
    for (int i = 0; i < 16; i++) step(32'h1000, 1);
    chk("hit_sat", 32'(hit_cnt), 32'hF);

    step(32'h5000, 1);
    step(32'h5000, 1, 1, 1, 32'h0000_00AA);
    chk("t3_busy", 32'(busy), 32'd0);
    step(32'h1000, 1);
    step(32'h1000, 1, 1);
    step(32'h1000, 1, 1);
    step(32'h1000, 0);

    step(32'h2000, 1);
    step(32'h3000, 1);
    step(32'h3000, 1, 0, 1, 32'hDEAD_BEEF);
    step(32'h2000, 1);
    step(32'h3000, 1);
    chk("t4_busy", 32'(busy), 32'd1);
    step(32'h3000, 1, 0, 1, 32'h0000_1234);
    step(32'h3000, 1);

    step(32'h2004, 1);
    step(32'h2004, 1, 0, 1, 32'h0000_0077, 0);
    chk("t5_busy", 32'(busy), 32'd1);
    step(32'h2004, 0);
    step(32'h2004, 1, 0, 1, 32'h0000_0077);
    step(32'h2004, 1);

    for (int i = 0; i < 10; i++) begin
      step(32'h8000 + 32'(i * 4), 1);
      step(32'h8000 + 32'(i * 4), 1, 0, 1, 32'(i));
    end
    chk("miss_sat", 32'(miss_cnt), 32'hF);

    step(32'h4000, 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t6_busy", 32'(busy), 32'd0);
    chk("t6_hit", 32'(hit_cnt), 32'd0);
    chk("t6_miss", 32'(miss_cnt), 32'd0);
    model_rst();
    @(negedge clk);
    rst_n = 1'b1;
    step(32'h2004, 0, 0, 1, 32'h0000_0099);
    step(32'h2004, 1);
    step(32'h2004, 1, 0, 1, 32'h0000_0055);
    step(32'h2004, 1);

    $display("Simulation finished: %0d checks, %0d errors",
             n_chk, n_err);
    $finish;
  end

endmodule
